// File: rtl/garage_door_pkg.sv
// Shared types and constants for the garage door opener controller.
package garage_door_pkg;

    typedef enum logic [2:0] {
        CLOSED,
        OPENING,
        OPEN,
        CLOSING,
        STOP_UP,
        STOP_DN
    } door_state_t;

    localparam int unsigned LED_MOVING = 2;
    localparam int unsigned LED_OPEN   = 1;
    localparam int unsigned LED_CLOSED = 0;

    // Status LED pattern for a given door state; STOP_* leaves all LEDs dark.
    function automatic logic [2:0] state_leds(input door_state_t s);
        logic [2:0] leds;
        leds = '0;
        case (s)
            OPENING, CLOSING: leds[LED_MOVING] = 1'b1;
            OPEN:             leds[LED_OPEN]   = 1'b1;
            CLOSED:           leds[LED_CLOSED] = 1'b1;
            default:          leds = '0;
        endcase
        return leds;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Pushbutton conditioner: 2-flop synchronizer, stability counter and a
// single-cycle pulse on each accepted rising level.
module button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic press
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync;
    logic          level;
    logic [CW-1:0] cnt;

    // The counter tracks consecutive samples disagreeing with the accepted
    // level; any agreeing sample restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync  <= '0;
            level <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync  <= {sync[0], raw};
            press <= 1'b0;
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync[1];
                cnt   <= '0;
                press <= sync[1];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/garage_door_ctrl.sv
// Single-button garage door sequencer: door FSM, travel position counter,
// optional auto-close timer and registered motor/LED outputs.
module garage_door_ctrl #(
    parameter int unsigned TRAVEL_CYCLES     = 50_000_000,
    parameter int unsigned DEBOUNCE_CYCLES   = 500_000,
    parameter int unsigned AUTO_CLOSE_CYCLES = 0
) (
    input  logic       sys_clk,
    input  logic       reset,
    input  logic       button,
    input  logic       safety,
    output logic       motor_up,
    output logic       motor_down,
    output logic       obstructed,
    output logic [2:0] LEDs
);

    import garage_door_pkg::*;

    localparam int unsigned PW = $clog2(TRAVEL_CYCLES + 1);
    localparam logic [PW-1:0] POS_FULL = PW'(TRAVEL_CYCLES);
    localparam logic [PW-1:0] POS_LAST = PW'(TRAVEL_CYCLES - 1);
    localparam logic [PW-1:0] POS_ONE  = PW'(1);

    localparam bit          AC_EN   = (AUTO_CLOSE_CYCLES > 0);
    localparam int unsigned AW      = (AUTO_CLOSE_CYCLES > 1) ? $clog2(AUTO_CLOSE_CYCLES) : 1;
    localparam logic [AW-1:0] AC_LAST = AW'((AUTO_CLOSE_CYCLES > 0) ? AUTO_CLOSE_CYCLES - 1 : 0);

    door_state_t   state, state_next;
    logic [PW-1:0] pos, pos_next;
    logic [AW-1:0] timer, timer_next;
    logic          obstructed_next;
    logic [1:0]    safety_sync;
    logic          safe;
    logic          press;
    logic          timeout;

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk  (sys_clk),
        .rst  (reset),
        .raw  (button),
        .press(press)
    );

    assign safe    = safety_sync[1];
    assign timeout = AC_EN && (timer == AC_LAST);

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state       <= CLOSED;
            pos         <= '0;
            timer       <= '0;
            obstructed  <= 1'b0;
            safety_sync <= '0;
        end else begin
            state       <= state_next;
            pos         <= pos_next;
            timer       <= timer_next;
            obstructed  <= obstructed_next;
            safety_sync <= {safety_sync[0], safety};
        end
    end

    // Priority is safety > limit arrival > press; a press that loses is still
    // consumed. The timer defaults to zero so every entry into OPEN starts it clean.
    always_comb begin
        state_next      = state;
        pos_next        = pos;
        timer_next      = '0;
        obstructed_next = obstructed;
        if (press) begin
            obstructed_next = 1'b0;
        end
        case (state)
            CLOSED: begin
                if (press) begin
                    state_next = OPENING;
                end
            end
            OPENING: begin
                if (pos == POS_LAST) begin
                    pos_next   = POS_FULL;
                    state_next = OPEN;
                end else if (press) begin
                    state_next = STOP_UP;
                end else begin
                    pos_next = pos + 1'b1;
                end
            end
            OPEN: begin
                if (press && !safe) begin
                    state_next = CLOSING;
                end else if (timeout) begin
                    if (!safe) begin
                        state_next = CLOSING;
                    end
                end else if (AC_EN) begin
                    timer_next = timer + 1'b1;
                end
            end
            CLOSING: begin
                if (safe) begin
                    state_next      = OPENING;
                    obstructed_next = 1'b1;
                end else if (pos == POS_ONE) begin
                    pos_next   = '0;
                    state_next = CLOSED;
                end else if (press) begin
                    state_next = STOP_DN;
                end else begin
                    pos_next = pos - 1'b1;
                end
            end
            STOP_UP: begin
                if (press && !safe) begin
                    state_next = CLOSING;
                end
            end
            STOP_DN: begin
                if (press) begin
                    state_next = OPENING;
                end
            end
            default: begin
                state_next = CLOSED;
                pos_next   = '0;
            end
        endcase
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            motor_up   <= 1'b0;
            motor_down <= 1'b0;
            LEDs       <= state_leds(CLOSED);
        end else begin
            motor_up   <= (state == OPENING);
            motor_down <= (state == CLOSING);
            LEDs       <= state_leds(state);
        end
    end

endmodule
